// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and ratio constants for the divider config controller.
// NACK exists only when CLKDIV_CFG_RANGE_CHECK_EN is defined.
package clkdiv_pkg;
  localparam logic [15:0] DEFAULT_N = 16'd4;
  localparam int unsigned MIN_N = 2;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
`ifdef CLKDIV_CFG_RANGE_CHECK_EN
    , NACK
`endif
  } state_t;
endpackage

// File: rtl/clkdiv_cfg_ctrl_rr_arb.sv
// rr_arb: round-robin grant of the first active requester at or after ptr.
module rr_arb #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  // Scan from farthest to nearest so the nearest active requester wins.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/clkdiv_cfg_ctrl.sv
// clkdiv_cfg_ctrl: arbitrates divide-ratio change requests and applies them only at period boundaries.
// Define CLKDIV_CFG_RANGE_CHECK_EN to reject ratios below MIN_N with a nack pulse.
module clkdiv_cfg_ctrl
  import clkdiv_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W = 16,
  parameter logic [W-1:0] DEFAULT_N = W'(clkdiv_pkg::DEFAULT_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_n,
  output logic [NREQ-1:0]   ack,
`ifdef CLKDIV_CFG_RANGE_CHECK_EN
  output logic [NREQ-1:0]   nack,
`endif
  output logic [W-1:0]      div_n,
  output logic              div_sync,
  output logic              busy
);
  localparam int IW = $clog2(NREQ);
  state_t state, nxt;
  logic [W-1:0] cnt, pending, sel_n;
  logic [IW-1:0] ptr, grant_idx, idx;
  logic [NREQ-1:0] grant;
  logic wrap, low;
  rr_arb #(.N(NREQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );
  assign sel_n = req_n[int'(idx)*W +: W];
  assign wrap = (div_n <= W'(1)) || (cnt >= div_n - W'(1));
  assign div_sync = wrap;
  assign busy = state != IDLE;
  assign ack = (state == ACK) ? NREQ'(1) << grant_idx : '0;
`ifdef CLKDIV_CFG_RANGE_CHECK_EN
  assign low = sel_n < W'(MIN_N);
  assign nack = (state == NACK) ? NREQ'(1) << grant_idx : '0;
`else
  assign low = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (|grant) nxt = low ? state_t'(3) : WAIT;
      WAIT: if (wrap) nxt = ACK;
      default: nxt = IDLE;
    endcase
  end
  // The counter reloads on every wrap, so a ratio applied at a wrap starts a clean period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      div_n <= DEFAULT_N;
      ptr <= '0;
      grant_idx <= '0;
      pending <= '0;
    end else begin
      state <= nxt;
      cnt <= wrap ? '0 : cnt + W'(1);
      if (state == IDLE && |grant) begin
        grant_idx <= idx;
        pending <= sel_n;
      end
      if (state == WAIT && wrap) div_n <= pending;
      if (state != IDLE && state != WAIT)
        ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// tb_clkdiv_cfg_ctrl: directed checks of reset, ratio changes, round-robin order, range handling and reset abort.
module tb_clkdiv_cfg_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [63:0] req_n;
  logic [3:0] ack, nk;
  logic [15:0] div_n;
  logic div_sync, busy;
  int total = 0;
  int bad = 0;
  clkdiv_cfg_ctrl dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_n(req_n),
    .ack(ack),
`ifdef CLKDIV_CFG_RANGE_CHECK_EN
    .nack(nk),
`endif
    .div_n(div_n),
    .div_sync(div_sync),
    .busy(busy)
  );
`ifndef CLKDIV_CFG_RANGE_CHECK_EN
  assign nk = '0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input int budget, output logic [3:0] a, output logic [3:0] na, output logic [15:0] dn);
    a = '0;
    na = '0;
    dn = '0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ack != 0 || nk != 0) begin
        a = ack;
        na = nk;
        dn = div_n;
        req = req & ~(ack | nk);
        return;
      end
    end
  endtask
  logic [7:0] v1;
  logic [11:0] v2;
  logic [3:0] v3, a, na, acc;
  logic [15:0] dn;
  initial begin
    rst = 1'b1;
    req = '0;
    req_n = '0;
    #1;
    chk("rst_div_n", div_n, 16'd4);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_sync", div_sync, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v1[k] = div_sync;
      step();
    end
    chk("idle_sync_pattern", v1, 8'h88);
    chk("idle_busy", busy, 0);
    step();
    req[2] = 1'b1;
    req_n[2*16 +: 16] = 16'd6;
    step();
    chk("grant_busy", busy, 1);
    chk("wait_div_n", div_n, 16'd4);
    step();
    chk("wait_wrap_sync", div_sync, 1);
    chk("wait_hold_div_n", div_n, 16'd4);
    step();
    chk("apply_div_n", div_n, 16'd6);
    chk("apply_ack", ack, 4'b0100);
    req = '0;
    step();
    chk("ack_one_cycle", ack, 0);
    chk("back_idle", busy, 0);
    for (int j = 0; j < 12; j++) begin
      v2[j] = div_sync;
      step();
    end
    chk("sync_period6", v2, 12'h410);
    req[1] = 1'b1;
    req_n[1*16 +: 16] = 16'd8;
    step();
    chk("wrap_grant_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_div_n", div_n, 16'd4);
    chk("abort_busy", busy, 0);
    req = '0;
    step();
    rst = 1'b0;
    acc = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      acc = acc | ack;
    end
    chk("abort_no_ack", acc, 0);
    chk("abort_keep_div_n", div_n, 16'd4);
    req[3] = 1'b1;
    req_n[3*16 +: 16] = 16'd4;
    wait_ack(20, a, na, dn);
    chk("fresh_ack", a, 4'b1000);
    chk("fresh_same_n", dn, 16'd4);
    req = 4'b1011;
    req_n[0*16 +: 16] = 16'd5;
    req_n[1*16 +: 16] = 16'd7;
    req_n[3*16 +: 16] = 16'd9;
    wait_ack(30, a, na, dn);
    chk("rr_first_ack", a, 4'b0001);
    chk("rr_first_n", dn, 16'd5);
    wait_ack(30, a, na, dn);
    chk("rr_second_ack", a, 4'b0010);
    chk("rr_second_n", dn, 16'd7);
    wait_ack(30, a, na, dn);
    chk("rr_third_ack", a, 4'b1000);
    chk("rr_third_n", dn, 16'd9);
    req[1] = 1'b1;
    req_n[1*16 +: 16] = 16'd1;
    wait_ack(30, a, na, dn);
`ifdef CLKDIV_CFG_RANGE_CHECK_EN
    chk("low_nack", na, 4'b0010);
    chk("low_no_ack", a, 0);
    chk("low_keep_div_n", dn, 16'd9);
`else
    chk("low_ack", a, 4'b0010);
    chk("low_div_n", dn, 16'd1);
    for (int j = 0; j < 4; j++) begin
      step();
      v3[j] = div_sync;
    end
    chk("n1_sync_every_cycle", v3, 4'hf);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clkdiv_cfg_ctrl.md
CLKDIV_CFG_CTRL -- requirements
Module: clkdiv_cfg_ctrl

Interface
REQ-001 Parameter NREQ, default 4, SHALL be the number of requesters (2..8).
REQ-002 Parameter W, default 16, SHALL be the divide-ratio width.
REQ-003 Parameter DEFAULT_N, default 16'd4, SHALL be the ratio driven after reset.
REQ-004 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester ratio-change request, level, held until ack or nack.
REQ-007 req_n  in  NREQ*W  requested ratios, packed; requester i uses bits [i*W +: W].
REQ-008 ack  out  NREQ  one-cycle pulse: requester's ratio has been applied.
REQ-009 nack  out  NREQ  one-cycle pulse: request rejected; present only with CLKDIV_CFG_RANGE_CHECK_EN.
REQ-010 div_n  out  W  active divide ratio, driven to the downstream divider's N input.
REQ-011 div_sync  out  1  one-cycle pulse on the last clk cycle of each divided period.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 A phase counter SHALL increment each clk and wrap to 0 when cnt >= div_n-1; for div_n of 0 or 1 it SHALL stay 0.
REQ-014 div_sync SHALL be high exactly in cycles where the phase counter is at its wrap point.
REQ-015 The FSM SHALL have the states IDLE, WAIT, ACK and, with the macro, NACK.
REQ-016 In IDLE with any req bit high, the round-robin arbiter SHALL grant the first active requester at or after ptr, modulo NREQ.
REQ-017 On that IDLE edge, the controller SHALL latch the granted index and the granted req_n slice into pending, then go to WAIT.
REQ-018 In WAIT, on the edge where the phase counter is at its wrap point, div_n SHALL load pending, the counter SHALL load 0, and the FSM SHALL go to ACK.
REQ-019 In ACK, ack[grant] SHALL be high for exactly one cycle, ptr SHALL become grant+1 mod NREQ, and the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be: grant one edge after req is sampled, apply at the first subsequent wrap point, ack in the next cycle.
REQ-021 div_n SHALL change only at a wrap point, so no divided period is truncated.
REQ-022 req and req_n SHALL be ignored in WAIT, ACK and NACK; the latched request SHALL complete even if req drops.
REQ-023 A requester SHALL deassert req in the cycle after ack or nack; a req still high in IDLE SHALL be treated as a new request.
REQ-024 Simultaneous requests SHALL be served one per transaction in round-robin order, with no requester starved more than NREQ-1 transactions.
REQ-025 Requesting the current value SHALL still wait for a wrap point and produce ack.

Reset
REQ-026 On rst, the block SHALL set div_n=DEFAULT_N, phase counter=0, state=IDLE, ptr=0, pending=0, and ack=nack=busy=div_sync=0.
REQ-027 rst during WAIT or ACK SHALL discard the pending request with no ack or nack issued.

Configuration
REQ-028 With CLKDIV_CFG_RANGE_CHECK_EN defined, a granted ratio below 2 SHALL go to NACK; nack[grant] SHALL pulse one cycle, div_n stays unchanged, ptr advances, then IDLE.
REQ-029 Without CLKDIV_CFG_RANGE_CHECK_EN, the nack port and the NACK state SHALL be absent and every ratio SHALL be applied.

Structure
REQ-030 Package clkdiv_pkg SHALL hold the FSM state enum, DEFAULT_N, and the minimum legal ratio constant (2).
REQ-031 Round-robin grant logic SHALL be a sub-module, rr_arb, taking req and ptr and producing a one-hot grant plus a binary index.

Verification
REQ-032 Reset release with no req: div_n=4; div_sync pulses every 4 cycles; busy=0.
REQ-033 With div_n=4 at phase 1, req[2] is raised with N=6: grant on the next edge, div_n=6 at the wrap edge, then ack[2] for 1 cycle; div_sync thereafter every 6 cycles.
REQ-034 req[0], req[1] and req[3] are raised together with N=5, 7 and 9 and ptr=0: the ratios are applied in the order 5, 7, 9, and the acks arrive in order 0, 1, 3.
REQ-035 With the macro defined, req[1] with N=1: nack[1] pulses, div_n is unchanged, and no ack occurs; without the macro, div_n becomes 1 and the counter holds 0.
REQ-036 rst is asserted in WAIT with pending N=8: after release, div_n=4 and there is no ack; a fresh request then completes normally.
